// File: rtl/ext_reg_requester_pkg.sv
// rtl/ext_reg_requester_pkg.sv - shared types and constants for the external-register requester
package ext_reg_pkg;

  localparam int EXT_REQ_DEFAULT_TIMEOUT = 64;
  // Widest configuration exercised alongside the block; the RTL itself is parameterized.
  localparam int EXT_REQ_WIDTH    = 32;
  localparam int EXT_REQ_SUBWORDS = 4;

  typedef enum logic [1:0] {
    EXT_REQ_IDLE = 2'd0,
    EXT_REQ_REQ  = 2'd1,
    EXT_REQ_WAIT = 2'd2,
    EXT_REQ_RESP = 2'd3
  } ext_req_state_e;

  typedef struct packed {
    logic                        is_wr;
    logic [EXT_REQ_SUBWORDS-1:0] strb;
    logic [EXT_REQ_WIDTH-1:0]    wr_data;
    logic [EXT_REQ_WIDTH-1:0]    wr_biten;
  } ext_req_cmd_t;

endpackage

// File: rtl/ext_reg_requester_if.sv
// rtl/ext_reg_requester_if.sv - host command/response channel and external-register strobe bus
interface ext_reg_requester_if #(
  parameter int WIDTH    = 32,
  parameter int SUBWORDS = 1
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_is_wr;
  logic [SUBWORDS-1:0] cmd_strb;
  logic [WIDTH-1:0]    cmd_wr_data;
  logic [WIDTH-1:0]    cmd_wr_biten;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WIDTH-1:0]    rsp_rd_data;
  logic                rsp_err;
  logic [SUBWORDS-1:0] req;
  logic                req_is_wr;
  logic [WIDTH-1:0]    wr_data;
  logic [WIDTH-1:0]    wr_biten;
  logic                rd_ack;
  logic [WIDTH-1:0]    rd_data;
  logic                wr_ack;

  modport master (
    input  cmd_valid, cmd_is_wr, cmd_strb, cmd_wr_data, cmd_wr_biten, rsp_ready,
           rd_ack, rd_data, wr_ack,
    output cmd_ready, rsp_valid, rsp_rd_data, rsp_err, req, req_is_wr, wr_data, wr_biten
  );

  modport slave (
    output cmd_valid, cmd_is_wr, cmd_strb, cmd_wr_data, cmd_wr_biten, rsp_ready,
           rd_ack, rd_data, wr_ack,
    input  cmd_ready, rsp_valid, rsp_rd_data, rsp_err, req, req_is_wr, wr_data, wr_biten
  );
endinterface

// File: rtl/ext_req_timer.sv
// rtl/ext_req_timer.sv - transaction timeout counter, used only when EXT_REG_REQ_TIMEOUT_EN is defined
module ext_req_timer
  import ext_reg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = EXT_REQ_DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The cycle in which the count would reach the limit is the expiring one.
  assign expired = count_en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ext_reg_requester.sv
// rtl/ext_reg_requester.sv - one-at-a-time external-register initiator; timeout under EXT_REG_REQ_TIMEOUT_EN
module ext_reg_requester
  import ext_reg_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int SUBWORDS       = 1,
  parameter int TIMEOUT_CYCLES = EXT_REQ_DEFAULT_TIMEOUT
) (
  input logic              clk,
  input logic              rst_n,
  ext_reg_requester_if.master bus
);
  localparam logic [1:0] S_IDLE = 2'(EXT_REQ_IDLE);
  localparam logic [1:0] S_REQ  = 2'(EXT_REQ_REQ);
  localparam logic [1:0] S_WAIT = 2'(EXT_REQ_WAIT);
  localparam logic [1:0] S_RESP = 2'(EXT_REQ_RESP);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [1:0]          state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0]    rsp_rd_data_q, rsp_rd_data_d;
  logic [SUBWORDS-1:0] req_q, req_d;
  logic                req_is_wr_q, req_is_wr_d;
  logic [WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [WIDTH-1:0]    wr_biten_q, wr_biten_d;
  logic                in_flight;
  logic                ack_match;
  logic                expired;

  assign in_flight = (state_q == S_REQ) || (state_q == S_WAIT);
  assign ack_match = req_is_wr_q ? bus.wr_ack : bus.rd_ack;

`ifdef EXT_REG_REQ_TIMEOUT_EN
  ext_req_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == S_IDLE),
    .count_en(in_flight),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    rsp_err_d     = rsp_err_q;
    rsp_rd_data_d = rsp_rd_data_q;
    req_d         = '0;
    req_is_wr_d   = req_is_wr_q;
    wr_data_d     = wr_data_q;
    wr_biten_d    = wr_biten_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          if (bus.cmd_strb == '0) begin
            state_d       = S_RESP;
            rsp_err_d     = 1'b1;
            rsp_rd_data_d = '0;
          end else begin
            state_d     = S_REQ;
            req_d       = bus.cmd_strb;
            req_is_wr_d = bus.cmd_is_wr;
            wr_data_d   = bus.cmd_wr_data;
            wr_biten_d  = bus.cmd_wr_biten;
          end
        end
      end
      S_REQ, S_WAIT: begin
        // A matching ack outranks a timeout expiring on the same edge.
        if (ack_match) begin
          state_d       = S_RESP;
          rsp_err_d     = 1'b0;
          rsp_rd_data_d = req_is_wr_q ? '0 : bus.rd_data;
        end else if (expired) begin
          state_d       = S_RESP;
          rsp_err_d     = 1'b1;
          rsp_rd_data_d = '0;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        if (bus.rsp_ready) begin
          state_d       = S_IDLE;
          rsp_err_d     = 1'b0;
          rsp_rd_data_d = '0;
        end
      end
    endcase
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rd_data_q <= '0;
      req_q         <= '0;
      req_is_wr_q   <= 1'b0;
      wr_data_q     <= '0;
      wr_biten_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_rd_data_q <= rsp_rd_data_d;
      req_q         <= req_d;
      req_is_wr_q   <= req_is_wr_d;
      wr_data_q     <= wr_data_d;
      wr_biten_q    <= wr_biten_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_rd_data = rsp_rd_data_q;
  assign bus.req         = req_q;
  assign bus.req_is_wr   = req_is_wr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.wr_biten    = wr_biten_q;

endmodule

// File: tb/tb_ext_reg_requester.sv
// tb/tb_ext_reg_requester.sv - randomized self-checking bench with a transaction-timeline model
module tb_ext_reg_requester;
  import ext_reg_pkg::*;

  localparam int W  = EXT_REQ_WIDTH;
  localparam int SW = EXT_REQ_SUBWORDS;
  localparam int T  = 8;
`ifdef EXT_REG_REQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ext_reg_requester_if #(.WIDTH(W), .SUBWORDS(SW)) bus ();

  ext_reg_requester #(
    .WIDTH(W), .SUBWORDS(SW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  bit            chk_en = 1'b0;
  bit            exp_qual;
  logic          exp_cmd_ready, exp_rsp_valid, exp_rsp_err;
  logic [W-1:0]  exp_rsp_rd_data, exp_wr_data, exp_wr_biten;
  logic [SW-1:0] exp_req;
  logic          exp_req_is_wr;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Single compare process: outputs sampled mid-cycle against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", W'(bus.cmd_ready), W'(exp_cmd_ready));
      chk("rsp_valid", W'(bus.rsp_valid), W'(exp_rsp_valid));
      chk("rsp_err", W'(bus.rsp_err), W'(exp_rsp_err));
      chk("rsp_rd_data", bus.rsp_rd_data, exp_rsp_rd_data);
      chk("req", W'(bus.req), W'(exp_req));
      if (exp_qual) begin
        chk("req_is_wr", W'(bus.req_is_wr), W'(exp_req_is_wr));
        chk("wr_data", bus.wr_data, exp_wr_data);
        chk("wr_biten", bus.wr_biten, exp_wr_biten);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.rd_ack    = 1'b0;
    bus.wr_ack    = 1'b0;
    bus.rd_data   = W'($urandom);
  endtask

  task automatic exp_idle(input logic rdy);
    exp_cmd_ready   = rdy;
    exp_rsp_valid   = 1'b0;
    exp_rsp_err     = 1'b0;
    exp_rsp_rd_data = '0;
    exp_req         = '0;
    exp_qual        = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input bit stray_rd_ack);
    for (int i = 0; i < n; i++) begin
      step();
      clear_inputs();
      bus.rd_ack = stray_rd_ack;
      bus.wr_ack = stray_rd_ack;
      exp_idle(1'b1);
    end
  endtask

  // Called in a cycle where the requester is idle with cmd_ready=1; returns in the
  // cycle after the response handshake. right_k: matching ack k cycles after the req
  // cycle (-1 = never). The response start (cycles after acceptance) follows from
  // the protocol's latency rules, not from the RTL.
  task automatic run_txn(input ext_req_cmd_t c, input logic [W-1:0] rdd, input int right_k,
                         input int hold, input bit force_wrong, input int pin_lat,
                         input logic [W-1:0] pin_data, input logic pin_err);
    int           rstart;
    logic         err;
    logic [W-1:0] rdata;
    bus.cmd_valid    = 1'b1;
    bus.cmd_is_wr    = c.is_wr;
    bus.cmd_strb     = c.strb;
    bus.cmd_wr_data  = c.wr_data;
    bus.cmd_wr_biten = c.wr_biten;
    bus.rd_ack       = 1'($urandom);
    bus.wr_ack       = 1'($urandom);
    if (c.strb == '0) begin
      rstart = 1; err = 1'b1; rdata = '0;
    end else if (right_k >= 0 && (!TO_EN || right_k < T)) begin
      rstart = right_k + 2; err = 1'b0; rdata = c.is_wr ? '0 : rdd;
    end else begin
      rstart = T + 1; err = 1'b1; rdata = '0;
    end
    if (pin_lat >= 0) chk("model_latency", W'(rstart), W'(pin_lat));
    for (int i = 1; i < 2000; i++) begin
      step();
      clear_inputs();
      exp_cmd_ready = 1'b0;
      if (i == right_k + 1) begin
        if (c.is_wr) bus.wr_ack = 1'b1;
        else begin bus.rd_ack = 1'b1; bus.rd_data = rdd; end
      end else if (i < rstart) begin
        if (c.is_wr) bus.rd_ack = force_wrong | ($urandom_range(0, 3) == 0);
        else         bus.wr_ack = force_wrong | ($urandom_range(0, 3) == 0);
      end else begin
        bus.rd_ack = 1'($urandom);
        bus.wr_ack = 1'($urandom);
      end
      if (i < rstart) begin
        exp_rsp_valid   = 1'b0;
        exp_rsp_err     = 1'b0;
        exp_rsp_rd_data = '0;
        exp_req         = (i == 1) ? c.strb : '0;
        exp_qual        = 1'b1;
        exp_req_is_wr   = c.is_wr;
        exp_wr_data     = c.wr_data;
        exp_wr_biten    = c.wr_biten;
      end else begin
        exp_rsp_valid   = 1'b1;
        exp_rsp_err     = err;
        exp_rsp_rd_data = rdata;
        exp_req         = '0;
        exp_qual        = 1'b0;
        if (i == pin_lat) begin
          chk("pin_rsp_valid", W'(bus.rsp_valid), W'(1));
          chk("pin_rsp_err", W'(bus.rsp_err), W'(pin_err));
          chk("pin_rsp_rd_data", bus.rsp_rd_data, pin_data);
        end
        if (i >= rstart + hold) begin
          bus.rsp_ready = 1'b1;
          break;
        end
      end
    end
    step();
    clear_inputs();
    bus.rd_ack = 1'($urandom);
    bus.wr_ack = 1'($urandom);
    exp_idle(1'b1);
  endtask

  task automatic reset_mid_wait();
    bus.cmd_valid    = 1'b1;
    bus.cmd_is_wr    = 1'b0;
    bus.cmd_strb     = 4'b0010;
    bus.cmd_wr_data  = 32'h1234_5678;
    bus.cmd_wr_biten = 32'h0000_FFFF;
    step();
    clear_inputs();
    exp_cmd_ready = 1'b0; exp_rsp_valid = 1'b0; exp_req = 4'b0010;
    exp_qual = 1'b1; exp_req_is_wr = 1'b0;
    exp_wr_data = 32'h1234_5678; exp_wr_biten = 32'h0000_FFFF;
    step();
    clear_inputs();
    exp_req = '0;
    rst_n = 1'b0;
    step();
    clear_inputs();
    rst_n      = 1'b1;
    bus.rd_ack = 1'b1;
    exp_idle(1'b0);
    exp_qual = 1'b1; exp_req_is_wr = 1'b0; exp_wr_data = '0; exp_wr_biten = '0;
    step();
    clear_inputs();
    exp_idle(1'b1);
  endtask

  initial begin
    ext_req_cmd_t c;
    rst_n = 1'b0;
    clear_inputs();
    bus.cmd_is_wr = 1'b0; bus.cmd_strb = '0; bus.cmd_wr_data = '0; bus.cmd_wr_biten = '0;
    exp_idle(1'b0);
    exp_qual = 1'b1; exp_req_is_wr = 1'b0; exp_wr_data = '0; exp_wr_biten = '0;
    step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    exp_idle(1'b1);

    c = '{is_wr: 1'b1, strb: 4'b0001, wr_data: 32'hDEADBEEF, wr_biten: 32'hFFFFFFFF};
    run_txn(c, 32'h0, 0, 0, 1'b0, 2, 32'h0, 1'b0);
    c = '{is_wr: 1'b0, strb: 4'b0001, wr_data: 32'h0, wr_biten: 32'h0};
    run_txn(c, 32'hDEADBEEF, 3, 4, 1'b0, 5, 32'hDEADBEEF, 1'b0);
    c = '{is_wr: 1'b1, strb: 4'b0100, wr_data: 32'hA5A5_0F0F, wr_biten: 32'h00FF_FF00};
    run_txn(c, 32'h0, 1, 1, 1'b0, 3, 32'h0, 1'b0);
    c = '{is_wr: 1'b1, strb: 4'b0000, wr_data: 32'h1111_2222, wr_biten: 32'hFFFF_FFFF};
    run_txn(c, 32'h0, 0, 2, 1'b0, 1, 32'h0, 1'b1);
    c = '{is_wr: 1'b0, strb: 4'b1000, wr_data: 32'h0, wr_biten: 32'h0};
    run_txn(c, 32'hCAFE_F00D, 4, 0, 1'b1, 6, 32'hCAFE_F00D, 1'b0);
    reset_mid_wait();
    idle_cycles(1, 1'b0);

    if (TO_EN) begin
      c = '{is_wr: 1'b0, strb: 4'b0011, wr_data: 32'h0, wr_biten: 32'h0};
      run_txn(c, 32'h5555_AAAA, -1, 1, 1'b0, T + 1, 32'h0, 1'b1);
      idle_cycles(1, 1'b1);
      run_txn(c, 32'h0BAD_CAFE, 2, 0, 1'b0, 4, 32'h0BAD_CAFE, 1'b0);
      run_txn(c, 32'h7777_8888, T - 1, 0, 1'b0, T + 1, 32'h7777_8888, 1'b0);
      run_txn(c, 32'h9999_0000, T, 0, 1'b0, T + 1, 32'h0, 1'b1);
    end

    for (int n = 0; n < 60; n++) begin
      c.is_wr    = 1'($urandom);
      c.strb     = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
      c.wr_data  = W'($urandom);
      c.wr_biten = W'($urandom);
      run_txn(c, W'($urandom),
              TO_EN ? $urandom_range(0, T + 2) - 1 : $urandom_range(0, 6),
              $urandom_range(0, 3), 1'b0, -1, '0, 1'b0);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3), 1'($urandom));
    end

    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
